// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, access owner
// encoding and the response-watchdog counter width.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, TOUT} arb_state_t;
  typedef enum logic {IFU, LSU} arb_owner_t;
  localparam int WD_W = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the IFU, LSU and memory-port handshakes of mem_arbiter.
// slave = the arbiter itself, master = the requesters plus the memory model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_resp_valid;
  logic [DATA_W-1:0]   lsu_rdata;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  logic bus_err;
  logic busy;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output bus_err, busy
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  bus_err, busy
  );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// Two-input round-robin grant: a lone requester wins, on contention the
// requester that did not win last time wins. Purely combinational.
module arb_rr2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,   // 0: req0 won last, 1: req1 won last
  output logic [1:0] gnt
);
  assign gnt[0] = req0 & (~req1 | last);
  assign gnt[1] = req1 & (~req0 | ~last);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic,
// one access at a time, with a response watchdog that flags bus_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  // Last RESP cycle index (0-based) in which a response would arrive too late.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  arb_owner_t          last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic                bus_err_q, bus_err_d;

  logic       idle;
  logic [1:0] gnt;
  logic       resp_ok, resp_to;

  assign idle = (state_q == IDLE);

  arb_rr2 u_rr (
    .req0 (idle & bus.ifu_req_valid),
    .req1 (idle & bus.lsu_req_valid),
    .last (last_q == LSU),
    .gnt  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wd_d      = wd_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          state_d = REQ;
          owner_d = LSU;
          last_d  = LSU;
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
        end else if (gnt[0]) begin
          state_d = REQ;
          owner_d = IFU;
          last_d  = IFU;
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = RESP;
          wd_d    = '0;
        end
      end
      RESP: begin
        // A response landing in the TIMEOUT-th RESP cycle is already too late.
        if (wd_q == WD_LAST)         state_d = TOUT;
        else if (bus.mem_resp_valid) state_d = IDLE;
        else                         wd_d    = wd_q + 1'b1;
      end
      TOUT: begin
        bus_err_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= IFU;
      last_q    <= IFU;
      wd_q      <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign resp_ok = (state_q == RESP) && (wd_q != WD_LAST) && bus.mem_resp_valid;
  assign resp_to = (state_q == TOUT);

  assign bus.ifu_req_ready  = gnt[0];
  assign bus.lsu_req_ready  = gnt[1];
  assign bus.ifu_resp_valid = (resp_ok | resp_to) && (owner_q == IFU);
  assign bus.lsu_resp_valid = (resp_ok | resp_to) && (owner_q == LSU);
  assign bus.ifu_rdata      = (resp_ok && owner_q == IFU) ? bus.mem_rdata : '0;
  assign bus.lsu_rdata      = (resp_ok && owner_q == LSU) ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.bus_err       = bus_err_q;
  assign bus.busy          = ~idle;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a transaction-level
// model: round-robin owner choice, a word memory, and a sticky error flag.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem_m [16];
  bit            last_lsu;   // model: LSU owned the previous access
  bit            err_m;      // model: a watchdog timeout has happened

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ifu_rdy"}, bus.ifu_req_ready, 0);
    chk({tag, "_lsu_rdy"}, bus.lsu_req_ready, 0);
    chk({tag, "_ifu_rsp"}, bus.ifu_resp_valid, 0);
    chk({tag, "_lsu_rsp"}, bus.lsu_resp_valid, 0);
    chk({tag, "_mreq"}, bus.mem_req_valid, 0);
    chk({tag, "_maddr"}, bus.mem_addr, 0);
    chk({tag, "_mwen"}, bus.mem_wen, 0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 0);
    chk({tag, "_mwmask"}, bus.mem_wmask, 0);
    chk({tag, "_err"}, bus.bus_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic chk_resp(input string tag, input bit pi, input bit pl, input logic [DW-1:0] d);
    chk({tag, "_ifu_rsp"}, bus.ifu_resp_valid, pi);
    chk({tag, "_lsu_rsp"}, bus.lsu_resp_valid, pl);
    if (pi) chk({tag, "_ifu_rdata"}, bus.ifu_rdata, d);
    if (pl) chk({tag, "_lsu_rdata"}, bus.lsu_rdata, d);
  endtask

  // One complete access starting in the next (IDLE) cycle. rdly = cycles of
  // mem_req_ready low; k = RESP cycle carrying the response (k > TO: none).
  task automatic access(input bit iv, input bit lv, input bit hold,
                        input logic [AW-1:0] ia, input logic [AW-1:0] la,
                        input bit wen, input logic [DW-1:0] wd, input logic [3:0] wm,
                        input int rdly, input int k);
    bit            g_lsu, done;
    logic [AW-1:0] ea;
    logic [DW-1:0] rd, expd;
    int            idx;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.ifu_req_valid  = iv;
    bus.ifu_addr       = ia;
    bus.lsu_req_valid  = lv;
    bus.lsu_addr       = la;
    bus.lsu_wen        = wen;
    bus.lsu_wdata      = wd;
    bus.lsu_wmask      = wm;
    #1;
    g_lsu    = (iv && lv) ? !last_lsu : lv;
    last_lsu = g_lsu;
    ea       = g_lsu ? la : ia;
    chk("grant_busy", bus.busy, 0);
    chk("grant_err", bus.bus_err, err_m);
    chk("grant_ifu_rdy", bus.ifu_req_ready, !g_lsu);
    chk("grant_lsu_rdy", bus.lsu_req_ready, g_lsu);
    for (int i = 0; i <= rdly; i++) begin
      tick();
      if (g_lsu) begin
        bus.lsu_req_valid = 1'b0;
        if (!hold) bus.ifu_req_valid = 1'b0;
      end else begin
        bus.ifu_req_valid = 1'b0;
        if (!hold) bus.lsu_req_valid = 1'b0;
      end
      bus.mem_req_ready = (i == rdly);
      #1;
      chk("req_valid", bus.mem_req_valid, 1);
      chk("req_addr", bus.mem_addr, ea);
      chk("req_wen", bus.mem_wen, g_lsu & wen);
      chk("req_wmask", bus.mem_wmask, g_lsu ? wm : 4'h0);
      if (g_lsu && wen) chk("req_wdata", bus.mem_wdata, wd);
      chk("req_ifu_rdy", bus.ifu_req_ready, 0);
      chk("req_lsu_rdy", bus.lsu_req_ready, 0);
    end
    // Bench memory accepts what the port presents.
    idx = int'(bus.mem_addr[5:2]);
    if (bus.mem_wen)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) mem_m[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    rd   = bus.mem_wen ? DW'($urandom) : mem_m[idx];
    expd = (g_lsu && wen) ? rd : mem_m[ea[5:2]];
    done = 1'b0;
    for (int j = 1; j <= TO && !done; j++) begin
      tick();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = (j == k);
      bus.mem_rdata      = (j == k) ? rd : DW'($urandom);
      #1;
      if (j == k && k < TO) begin
        chk_resp("resp", !g_lsu, g_lsu, expd);
        done = 1'b1;
      end else begin
        chk_resp("resp_wait", 0, 0, '0);
        chk("wait_busy", bus.busy, 1);
      end
    end
    if (!done) begin
      tick();
      bus.mem_resp_valid = 1'($urandom_range(0, 1));
      bus.mem_rdata      = DW'($urandom);
      #1;
      chk_resp("tout", !g_lsu, g_lsu, '0);
      err_m = 1'b1;
    end
  endtask

  initial begin
    clr_inputs();
    for (int i = 0; i < 16; i++) mem_m[i] = DW'($urandom);
    mem_m[0] = 32'h0000_0413;
    last_lsu = 1'b0;
    err_m    = 1'b0;
    #12;
    chk_reset("por");
    tick();
    rst = 1'b0;

    // Single IFU fetch, fastest memory.
    access(1, 0, 0, 32'h8000_0000, '0, 0, '0, 4'h0, 0, 1);

    // Contention from reset: LSU, then held IFU, then LSU again.
    tick();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    last_lsu = 1'b0;
    err_m    = 1'b0;
    access(1, 1, 1, 32'h8000_0004, 32'h8000_0008, 0, '0, 4'h0, 0, 1);
    access(1, 0, 0, 32'h8000_0004, '0, 0, '0, 4'h0, 0, 1);
    access(1, 1, 0, 32'h8000_000C, 32'h8000_0010, 0, '0, 4'h0, 1, 2);

    // Stalled store, then read it back through the partial mask.
    access(0, 1, 0, '0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'h3, 4, 1);
    access(0, 1, 0, '0, 32'h8000_0100, 0, '0, 4'h0, 0, 1);

    // Watchdog: no response, then a response exactly at the limit.
    access(0, 1, 0, '0, 32'h8000_0020, 0, '0, 4'h0, 0, TO + 1);
    access(1, 0, 0, 32'h8000_0024, '0, 0, '0, 4'h0, 0, TO);
    access(1, 1, 0, 32'h8000_0028, 32'h8000_002C, 0, '0, 4'h0, 2, TO - 1);

    // Reset in the middle of RESP.
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h8000_0030;
    bus.lsu_wen        = 1'b0;
    #1;
    chk("mid_grant", bus.lsu_req_ready, 1);
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("mid_req", bus.mem_req_valid, 1);
    tick();
    bus.mem_req_ready = 1'b0;
    #1;
    chk("mid_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async");
    tick();
    rst = 1'b0;
    last_lsu = 1'b0;
    err_m    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h1234_5678;
      #1;
      chk_resp("late", 0, 0, '0);
      chk("late_busy", bus.busy, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int            r;
      logic [AW-1:0] ia, la;
      r  = int'($urandom_range(1, 3));
      ia = 32'h8000_0000 | AW'($urandom_range(0, 15) << 2);
      la = 32'h8000_0000 | AW'($urandom_range(0, 15) << 2);
      access(r[0], r[1], 1'($urandom_range(0, 1)), ia, la, 1'($urandom_range(0, 1)),
             DW'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, TO + 1)));
    end
    tick();
    clr_inputs();
    tick();
    chk("final_busy", bus.busy, 0);
    chk("final_err", bus.bus_err, err_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the multicycle core's single memory port between instruction fetch (IFU) and load/store traffic (LSU, driven by the write-back stage's address/data/finish path). It accepts one request at a time over valid/ready handshakes, forwards it to the memory port, routes the response back to the owner, and guards each access with a response watchdog. It sits between IFU/WBU and the memory model/bus bridge.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles waiting for `mem_resp_valid` (1..255)
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-high
- `ifu_req_valid`  in  1  fetch request
- `ifu_req_ready`  out  1  fetch request accepted this cycle
- `ifu_addr`  in  ADDR_W  fetch address
- `ifu_resp_valid`  out  1  fetch data valid (1-cycle pulse)
- `ifu_rdata`  out  DATA_W  fetch data
- `lsu_req_valid`  in  1  load/store request
- `lsu_req_ready`  out  1  load/store request accepted
- `lsu_addr`  in  ADDR_W  load/store address
- `lsu_wen`  in  1  1 = store
- `lsu_wdata`  in  DATA_W  store data
- `lsu_wmask`  in  DATA_W/8  byte strobes
- `lsu_resp_valid`  out  1  load data / store done (1-cycle pulse)
- `lsu_rdata`  out  DATA_W  load data
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- `mem_resp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_W  memory read data
- `bus_err`  out  1  sticky watchdog-timeout flag
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, REQ, RESP, TOUT. Owner register `owner` ∈ {IFU, LSU}; `last` = owner of last granted access.
- IDLE: if any `*_req_valid`, grant one: single requester wins; both → the one that is not `last` (round-robin); after reset `last`=IFU, so LSU wins first contention. Granted `*_req_ready`=1 combinationally in that cycle only; addr/wen/wdata/wmask latched (IFU: wen=0, wmask=0); → REQ.
- REQ: `mem_req_valid`=1, fields stable; on `mem_req_ready` → RESP, watchdog cleared.
- RESP: watchdog increments each cycle; on `mem_resp_valid`: owner's `resp_valid`=1 and `rdata`=`mem_rdata` combinationally same cycle, → IDLE. If watchdog reaches TIMEOUT with no response: → TOUT.
- TOUT: owner's `resp_valid`=1, `rdata`=0, `bus_err` set, → IDLE.
- `mem_resp_valid` in IDLE/REQ/TOUT ignored (no response pulse). Non-owner `resp_valid` always 0.
- `bus_err` cleared only by `rst`.

## Timing
- Reset values: state IDLE, all `*_ready`/`*_resp_valid`/`mem_req_valid`=0, `mem_*` fields 0, `bus_err`=0, `busy`=0, `last`=IFU.
- Reset mid-transaction aborts immediately; outstanding request dropped, no response pulse.
- Minimum access: grant c0, `mem_req_valid` c1 (ready at c1), response c2, next grant c3 → 3 cycles/access.
- Response in same cycle as request handshake is illegal for memory and not observed.
- Timeout: response at RESP cycle k accepted for k ≤ TIMEOUT−1; otherwise TOUT pulse in the cycle after the TIMEOUT-th RESP cycle.
- Requester may drop `req_valid` before grant; no request is latched.

## Structure
- Package `mem_arb_pkg`: `arb_state_t` enum (IDLE/REQ/RESP/TOUT), `arb_owner_t` enum (IFU/LSU), watchdog counter width constant (8).
- Sub-module `arb_rr2`: two-input round-robin grant from (req0, req1, last) → one-hot grant; purely combinational, reused by later bus bridges.

## Test plan
- IFU only, addr 0x8000_0000, memory ready immediately, rdata 0x0000_0413 two cycles later → `ifu_req_ready` c0, `mem_req_valid` c1, `ifu_resp_valid`+rdata 0x413 c2, `busy` low c3.
- Both request after reset → LSU granted first; IFU held until LSU response, granted next IDLE; third contention grants LSU again.
- LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x3; `mem_req_ready` low 4 cycles → `mem_*` fields stable while `mem_req_valid` high, single `lsu_resp_valid`.
- No memory response, TIMEOUT=4 → `lsu_resp_valid` with rdata 0 after 4 RESP cycles, `bus_err`=1 and stays 1 across further good accesses.
- `rst` pulsed during RESP → all outputs reset values asynchronously; subsequent late `mem_resp_valid` produces no response pulse.
